// File: rtl/mem_arbiter.sv
// Arbitrates dcache/icache requests onto the single memory port and routes each
// completion back to the requester that owns its memory tag.
module mem_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      dcache2ctlr_command,
  input  logic [XLEN-1:0] dcache2ctlr_addr,
  input  logic [63:0]     dcache2ctlr_data,
  input  logic [1:0]      icache2ctlr_command,
  input  logic [XLEN-1:0] icache2ctlr_addr,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  output logic [3:0]      Ctlr2proc_response,
  output logic [63:0]     Ctlr2proc_data,
  output logic [3:0]      Ctlr2proc_tag,
  output logic [3:0]      Imem2proc_response,
  output logic [63:0]     Imem2proc_data,
  output logic [3:0]      Imem2proc_tag,
  output logic [4:0]      outstanding
);

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2,
    BUS_RSVD  = 2'd3
  } bus_cmd_e;

  typedef enum logic [1:0] {
    WIN_NONE,
    WIN_DCACHE,
    WIN_ICACHE
  } winner_e;

  typedef enum logic {
    OWN_DCACHE = 1'b0,
    OWN_ICACHE = 1'b1
  } owner_e;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [15:0] tag_valid;
  owner_e      tag_owner [16];
  logic [3:0]  starve_cnt;
  logic [4:0]  outstanding_q;

  logic        d_req;
  logic        i_req;
  winner_e     winner;
  logic        accept;
  logic        comp_hit;
  owner_e      comp_owner;
  logic [15:0] valid_next;
  logic [4:0]  pop_next;
  logic [3:0]  starve_next;

  // Arbitration: forced icache priority once the starvation counter saturates
  always_comb begin
    d_req  = bus_cmd_e'(dcache2ctlr_command) != BUS_NONE;
    i_req  = bus_cmd_e'(icache2ctlr_command) != BUS_NONE;
    winner = WIN_NONE;
    if (i_req && (starve_cnt == STARVE_MAX)) winner = WIN_ICACHE;
    else if (d_req)                           winner = WIN_DCACHE;
    else if (i_req)                           winner = WIN_ICACHE;
  end

  always_comb begin
    proc2mem_command   = BUS_NONE;
    proc2mem_addr      = '0;
    proc2mem_data      = '0;
    Ctlr2proc_response = '0;
    Imem2proc_response = '0;
    case (winner)
      WIN_DCACHE: begin
        proc2mem_command   = dcache2ctlr_command;
        proc2mem_addr      = dcache2ctlr_addr;
        proc2mem_data      = (bus_cmd_e'(dcache2ctlr_command) == BUS_STORE) ? dcache2ctlr_data : '0;
        Ctlr2proc_response = mem2proc_response;
      end
      WIN_ICACHE: begin
        proc2mem_command   = icache2ctlr_command;
        proc2mem_addr      = icache2ctlr_addr;
        Imem2proc_response = mem2proc_response;
      end
      default: ;
    endcase
  end

  assign accept = (winner != WIN_NONE) && (mem2proc_response != '0);

  // Completion routing reads the table before this edge's allocation lands
  always_comb begin
    comp_hit      = (mem2proc_tag != '0) && tag_valid[mem2proc_tag];
    comp_owner    = tag_owner[mem2proc_tag];
    Ctlr2proc_tag = '0;
    Imem2proc_tag = '0;
    if (comp_hit) begin
      if (comp_owner == OWN_DCACHE) Ctlr2proc_tag = mem2proc_tag;
      else                          Imem2proc_tag = mem2proc_tag;
    end
  end

  assign Ctlr2proc_data = mem2proc_data;
  assign Imem2proc_data = mem2proc_data;

  // Allocation is applied after the clear so a same-tag accept keeps the entry valid
  always_comb begin
    valid_next = tag_valid;
    if (comp_hit) valid_next[mem2proc_tag] = 1'b0;
    if (accept)   valid_next[mem2proc_response] = 1'b1;
    pop_next = '0;
    for (int unsigned i = 0; i < 16; i++) pop_next = pop_next + 5'(valid_next[i]);
  end

  always_comb begin
    starve_next = starve_cnt;
    if (!i_req)                                            starve_next = '0;
    else if (winner == WIN_ICACHE && mem2proc_response != '0) starve_next = '0;
    else if (winner == WIN_DCACHE && starve_cnt != STARVE_MAX) starve_next = starve_cnt + 4'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_valid     <= '0;
      starve_cnt    <= '0;
      outstanding_q <= '0;
      for (int unsigned i = 0; i < 16; i++) tag_owner[i] <= OWN_DCACHE;
    end else begin
      tag_valid     <= valid_next;
      starve_cnt    <= starve_next;
      outstanding_q <= pop_next;
      if (accept)
        tag_owner[mem2proc_response] <= (winner == WIN_ICACHE) ? OWN_ICACHE : OWN_DCACHE;
    end
  end

  assign outstanding = outstanding_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a reference model pushes expected outputs to a
// scoreboard queue as each step is driven; they are popped and checked at negedge.
module tb_mem_arbiter;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned LIMIT = 8;

  logic            clock;
  logic            reset;
  logic [1:0]      dcache2ctlr_command;
  logic [XLEN-1:0] dcache2ctlr_addr;
  logic [63:0]     dcache2ctlr_data;
  logic [1:0]      icache2ctlr_command;
  logic [XLEN-1:0] icache2ctlr_addr;
  logic [1:0]      proc2mem_command;
  logic [XLEN-1:0] proc2mem_addr;
  logic [63:0]     proc2mem_data;
  logic [3:0]      mem2proc_response;
  logic [63:0]     mem2proc_data;
  logic [3:0]      mem2proc_tag;
  logic [3:0]      Ctlr2proc_response;
  logic [63:0]     Ctlr2proc_data;
  logic [3:0]      Ctlr2proc_tag;
  logic [3:0]      Imem2proc_response;
  logic [63:0]     Imem2proc_data;
  logic [3:0]      Imem2proc_tag;
  logic [4:0]      outstanding;

  mem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .dcache2ctlr_command(dcache2ctlr_command), .dcache2ctlr_addr(dcache2ctlr_addr),
    .dcache2ctlr_data(dcache2ctlr_data),
    .icache2ctlr_command(icache2ctlr_command), .icache2ctlr_addr(icache2ctlr_addr),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag),
    .Ctlr2proc_response(Ctlr2proc_response), .Ctlr2proc_data(Ctlr2proc_data),
    .Ctlr2proc_tag(Ctlr2proc_tag),
    .Imem2proc_response(Imem2proc_response), .Imem2proc_data(Imem2proc_data),
    .Imem2proc_tag(Imem2proc_tag),
    .outstanding(outstanding)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]      cmd;
    logic [XLEN-1:0] addr;
    logic [63:0]     data;
    logic [3:0]      dresp;
    logic [3:0]      iresp;
    logic [3:0]      dtag;
    logic [3:0]      itag;
    logic [63:0]     pass;
    logic [4:0]      outs;
    logic [3:0]      starve;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: valid/owner (0 dcache, 1 icache), starvation, count
  logic       m_valid [16];
  logic       m_owner [16];
  logic [3:0] m_starve;
  logic [4:0] m_outs;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_owner[i] = 1'b0;
    end
    m_starve = '0;
    m_outs   = '0;
  endtask

  task automatic step(input string nm, input logic [1:0] dc, input logic [XLEN-1:0] da,
                      input logic [63:0] dd, input logic [1:0] ic, input logic [XLEN-1:0] ia,
                      input logic [3:0] rsp, input logic [3:0] ct);
    exp_t e;
    exp_t o;
    int   win;
    logic dreq, ireq, hit, acc;
    logic [63:0] cdata;
    @(posedge clock);
    #1;
    cdata = {32'hC0DE_0000, 28'h0, ct};
    dcache2ctlr_command = dc; dcache2ctlr_addr = da; dcache2ctlr_data = dd;
    icache2ctlr_command = ic; icache2ctlr_addr = ia;
    mem2proc_response = rsp; mem2proc_tag = ct; mem2proc_data = cdata;

    dreq = (dc != 2'd0);
    ireq = (ic != 2'd0);
    if (ireq && m_starve == 4'(LIMIT)) win = 2;
    else if (dreq)                     win = 1;
    else if (ireq)                     win = 2;
    else                               win = 0;
    e.cmd = 2'd0; e.addr = '0; e.data = '0; e.dresp = '0; e.iresp = '0;
    if (win == 1) begin
      e.cmd = dc; e.addr = da; e.data = (dc == 2'd2) ? dd : 64'd0; e.dresp = rsp;
    end else if (win == 2) begin
      e.cmd = ic; e.addr = ia; e.iresp = rsp;
    end
    hit = (ct != 4'd0) && m_valid[ct];
    e.dtag   = (hit && m_owner[ct] == 1'b0) ? ct : 4'd0;
    e.itag   = (hit && m_owner[ct] == 1'b1) ? ct : 4'd0;
    e.pass   = cdata;
    e.outs   = m_outs;
    e.starve = m_starve;
    exp_q.push_back(e);

    acc = (win != 0) && (rsp != 4'd0);
    if (acc && m_valid[rsp] && !(hit && ct == rsp)) begin
      errors++;
      $error("FAIL %s protocol violation accept onto valid tag %0d", nm, rsp);
    end
    if (hit) m_valid[ct] = 1'b0;
    if (acc) begin
      m_valid[rsp] = 1'b1;
      m_owner[rsp] = (win == 2);
    end
    if (!ireq)                        m_starve = '0;
    else if (win == 2 && rsp != 4'd0) m_starve = '0;
    else if (win == 1 && m_starve != 4'(LIMIT)) m_starve = m_starve + 4'd1;
    m_outs = '0;
    for (int i = 0; i < 16; i++) m_outs = m_outs + 5'(m_valid[i]);

    @(negedge clock);
    o = exp_q.pop_front();
    chk({nm, ".cmd"},    64'(proc2mem_command),   64'(o.cmd));
    chk({nm, ".addr"},   64'(proc2mem_addr),      64'(o.addr));
    chk({nm, ".data"},   proc2mem_data,           o.data);
    chk({nm, ".dresp"},  64'(Ctlr2proc_response), 64'(o.dresp));
    chk({nm, ".iresp"},  64'(Imem2proc_response), 64'(o.iresp));
    chk({nm, ".dtag"},   64'(Ctlr2proc_tag),      64'(o.dtag));
    chk({nm, ".itag"},   64'(Imem2proc_tag),      64'(o.itag));
    chk({nm, ".dpass"},  Ctlr2proc_data,          o.pass);
    chk({nm, ".ipass"},  Imem2proc_data,          o.pass);
    chk({nm, ".outs"},   64'(outstanding),        64'(o.outs));
    chk({nm, ".starve"}, 64'(dut.starve_cnt),     64'(o.starve));
  endtask

  task automatic idle(input string nm);
    step(nm, 2'd0, '0, '0, 2'd0, '0, 4'd0, 4'd0);
  endtask

  initial begin
    reset = 1'b0;
    dcache2ctlr_command = '0; dcache2ctlr_addr = '0; dcache2ctlr_data = '0;
    icache2ctlr_command = '0; icache2ctlr_addr = '0;
    mem2proc_response = '0; mem2proc_data = '0; mem2proc_tag = 4'd5;
    model_clear();
    #2;
    chk("rst.outs",   64'(outstanding),   64'd0);
    chk("rst.starve", 64'(dut.starve_cnt), 64'd0);
    chk("rst.dtag",   64'(Ctlr2proc_tag), 64'd0);
    chk("rst.itag",   64'(Imem2proc_tag), 64'd0);
    chk("rst.cmd",    64'(proc2mem_command), 64'd0);
    #5 reset = 1'b1;

    // Lone dcache load accepted at tag 3, then completed
    step("d_load", 2'd1, 32'h100, 64'hDEAD, 2'd0, '0, 4'd3, 4'd0);
    idle("d_hold");
    step("d_comp", 2'd0, '0, '0, 2'd0, '0, 4'd0, 4'd3);
    idle("d_drain");

    // Both requesting every cycle, all accepted: icache forced through at cycle 8
    for (int i = 0; i < 10; i++)
      step($sformatf("starve%0d", i), 2'd2, 32'h1000 + 32'(i * 8), 64'hABCD_0000 + 64'(i),
           2'd1, 32'h4000 + 32'(i * 4), 4'(i + 1), 4'd0);
    for (int i = 1; i <= 10; i++)
      step($sformatf("drain%0d", i), 2'd0, '0, '0, 2'd0, '0, 4'd0, 4'(i));
    idle("drain_done");

    // All rejected: counter saturates, then holds while forced icache keeps losing at memory
    for (int i = 0; i < 10; i++)
      step($sformatf("reject%0d", i), 2'd1, 32'h2000, '0, 2'd1, 32'h5000, 4'd0, 4'd0);
    idle("reject_clear");

    // Owner routing: icache at tag 5, dcache at tag 6, completions 6 then 5
    step("i_t5", 2'd0, '0, '0, 2'd1, 32'h6000, 4'd5, 4'd0);
    step("d_t6", 2'd2, 32'h6100, 64'h1234_5678, 2'd0, '0, 4'd6, 4'd0);
    step("comp6", 2'd0, '0, '0, 2'd0, '0, 4'd0, 4'd6);
    step("comp5", 2'd0, '0, '0, 2'd0, '0, 4'd0, 4'd5);

    // Completion on an unallocated tag is dropped
    step("d_t7", 2'd1, 32'h7000, '0, 2'd0, '0, 4'd7, 4'd0);
    step("comp9", 2'd0, '0, '0, 2'd0, '0, 4'd0, 4'd9);
    step("comp7", 2'd0, '0, '0, 2'd0, '0, 4'd0, 4'd7);

    // Same-tag completion and reallocation in one cycle
    step("d_t4", 2'd1, 32'h200, '0, 2'd0, '0, 4'd4, 4'd0);
    step("swap4", 2'd0, '0, '0, 2'd1, 32'h300, 4'd4, 4'd4);
    step("comp4i", 2'd0, '0, '0, 2'd0, '0, 4'd0, 4'd4);
    idle("swap_done");

    // Mid-operation reset with three tags outstanding and a nonzero starve count
    step("pre1", 2'd1, 32'h800, '0, 2'd1, 32'h900, 4'd1, 4'd0);
    step("pre2", 2'd1, 32'h808, '0, 2'd1, 32'h900, 4'd2, 4'd0);
    step("pre3", 2'd1, 32'h810, '0, 2'd1, 32'h900, 4'd3, 4'd0);
    @(posedge clock);
    #1;
    dcache2ctlr_command = '0; icache2ctlr_command = '0;
    mem2proc_response = '0; mem2proc_tag = '0;
    #2 reset = 1'b0;
    model_clear();
    #1;
    chk("midrst.outs",   64'(outstanding),    64'd0);
    chk("midrst.starve", 64'(dut.starve_cnt), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    step("post_comp2", 2'd0, '0, '0, 2'd0, '0, 4'd0, 4'd2);
    idle("post_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sits between the L1 caches and the single system-memory port. Each cycle it picks one of the data-cache (MSHR issue) or instruction-cache requests and forwards it to memory, returning the accept tag to the winner. It records which requester owns every outstanding memory tag, so each completion (tag + data) is delivered only to its owner. A starvation counter stops fixed data-side priority from locking out instruction fetch.

## Interface
- STARVE_LIMIT, 8: consecutive cycles the icache may lose arbitration before it gets forced priority (1..15)
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- dcache2ctlr_command  in  2  dcache request: BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2
- dcache2ctlr_addr  in  XLEN  dcache request address, 8-byte aligned
- dcache2ctlr_data  in  64  dcache store data
- icache2ctlr_command  in  2  icache request: BUS_NONE or BUS_LOAD only
- icache2ctlr_addr  in  XLEN  icache request address
- proc2mem_command  out  2  forwarded command
- proc2mem_addr  out  XLEN  forwarded address
- proc2mem_data  out  64  forwarded store data; 0 for loads
- mem2proc_response  in  4  memory accept tag; 0 = rejected
- mem2proc_data  in  64  completion data
- mem2proc_tag  in  4  completion tag; 0 = none
- Ctlr2proc_response  out  4  accept tag to dcache; 0 unless dcache won
- Ctlr2proc_data  out  64  mem2proc_data passed through
- Ctlr2proc_tag  out  4  completion tag to dcache; 0 unless dcache owns it
- Imem2proc_response  out  4  accept tag to icache; 0 unless icache won
- Imem2proc_data  out  64  mem2proc_data passed through
- Imem2proc_tag  out  4  completion tag to icache; 0 unless icache owns it
- outstanding  out  5  count of valid owner-table entries

## Operation
- Arbitration (combinational):
  - Default winner is dcache if its command != BUS_NONE, else icache if its command != BUS_NONE, else none.
  - If starve_cnt == STARVE_LIMIT and icache is requesting, icache wins.
- Forwarding: the winner's command, addr and data drive proc2mem_*. No winner -> BUS_NONE, addr 0, data 0.
- Accept return: mem2proc_response goes to the winner's *_response output. The loser's response is 0.
- Owner table: 16 entries {valid, owner}; entry 0 is never used.
  - Accepted request (winner present and mem2proc_response != 0): entry[mem2proc_response] <= {1, winner}.
- Completion (mem2proc_tag != 0):
  - If entry[tag].valid, drive the tag on the owner's *_tag output only, and clear valid at the next edge.
  - If the entry is invalid, drop it: both tag outputs stay 0.
- Simultaneous completion and acceptance with the same tag: the completion is routed using the old entry, and the new allocation wins the write.
- Acceptance onto an already-valid tag overwrites the entry; this is a memory protocol violation and the bench flags it.
- Starvation counter starve_cnt, width 4, saturates at STARVE_LIMIT:
  - Increments when the icache requests and dcache wins.
  - Clears when the icache is accepted, or when the icache is idle.
  - Holds when the icache wins but is rejected (response 0).
- outstanding = population count of valid entries, registered.

## Timing
- Request path: zero latency; proc2mem_* and *_response are combinational in the same cycle.
- Completion routing: zero latency, combinational from mem2proc_tag and the current table.
- State (table, starve_cnt, outstanding): updated at posedge; visible the following cycle.
- Reset (async, low): table cleared, starve_cnt = 0, outstanding = 0. Combinational outputs follow inputs with an empty table, so all *_tag outputs are 0.
- Completions for tags issued before a mid-operation reset are dropped.
- A requester rejected by memory retries by holding its command; the arbiter keeps no request state.

## Test plan
- Dcache LOAD addr 0x100 alone, mem response 3 -> proc2mem_command=1, Ctlr2proc_response=3, Imem2proc_response=0. Later mem2proc_tag=3 -> Ctlr2proc_tag=3, Imem2proc_tag=0, and outstanding falls 1->0.
- Both request every cycle, STARVE_LIMIT=8, memory accepts all:
  - dcache wins cycles 0-7 and icache wins cycle 8.
  - starve_cnt then clears and dcache wins cycle 9.
- Icache granted at tag 5 and dcache at tag 6. Completion 6 then 5 -> only Ctlr2proc_tag=6, then only Imem2proc_tag=5.
- Completion tag 9 with no valid entry -> both tag outputs 0, outstanding unchanged.
- Completion tag 4 and new accept tag 4 in the same cycle -> the old owner receives tag 4, and the entry is valid for the new owner next cycle.
- Assert reset with 3 outstanding, deassert, then drive completion tag 2 -> dropped, outstanding=0, starve_cnt=0.
